// File: rtl/spi_flash_reader.sv
// Read-only SPI flash bridge: turns 32-bit bus word reads into single-bit READ (0x03)
// transactions and returns the four received bytes as one little-endian word.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [1:0]  state_dbg
);

  // Bus handshake: a request is accepted on the rising edge where req_i && gnt_o;
  // exactly one rvalid_o pulse follows per accepted request, and gnt_o stays low
  // until that response and the CS gap have completed.
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, RESP = 2'd2, GAP = 2'd3} state_t;

  localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  state_t           state;
  logic [31:0]      tx_sr;
  logic [31:0]      rx_sr;
  logic [6:0]       bit_cnt;
  logic [7:0]       div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [31:0]      tx_load;

  assign tx_load   = {8'h03, addr_i[23:2], 2'b00};
  assign gnt_o     = req_i && (state == IDLE) && rst_n;
  assign busy_o    = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      gap_cnt  <= '0;
      spi_sck  <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            if (we_i) begin
              state    <= RESP;
              rvalid_o <= 1'b1;
              err_o    <= 1'b1;
              rdata_o  <= '0;
            end else begin
              tx_sr    <= tx_load;
              spi_mosi <= tx_load[31];
              spi_cs_n <= 1'b0;
              div_cnt  <= '0;
              bit_cnt  <= '0;
              state    <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (div_cnt == 8'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            spi_sck <= ~spi_sck;
            if (!spi_sck) begin
              // Rising edge: only the last 32 bits carry flash data.
              bit_cnt <= bit_cnt + 7'd1;
              if (bit_cnt >= 7'd32) rx_sr <= {rx_sr[30:0], spi_miso};
            end else begin
              tx_sr    <= {tx_sr[30:0], 1'b0};
              spi_mosi <= tx_sr[30];
              if (bit_cnt == 7'd64) begin
                state    <= RESP;
                spi_cs_n <= 1'b1;
                rvalid_o <= 1'b1;
                err_o    <= 1'b0;
                rdata_o  <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        RESP: begin
          rvalid_o <= 1'b0;
          err_o    <= 1'b0;
          rdata_o  <= '0;
          gap_cnt  <= '0;
          state    <= GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_W'(CS_GAP - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
